stepper_scheduler: RTL

Scheduler that shares the 8-state step sequencer (the data_in-driven s0..s7 stepper) between two requesters. It grants one requester at a time, round-robin, and drives the stepper's advance input with paced one-cycle pulses. Each grant runs one full pass of exactly 8 advances, which returns the stepper from s0 to s0. The block sits between the requesting control logic and the stepper's data_in input.

---
 rtl/stepper_scheduler_pkg.sv | 37 +++
 rtl/stepper_scheduler_if.sv | 34 +++
 rtl/stepper_scheduler_dwell_timer.sv | 32 +++
 rtl/stepper_scheduler.sv | 117 +++++++++++
 4 files changed

// File: rtl/stepper_scheduler_pkg.sv
// Shared types and constants for the two-requester stepper scheduler.
// The state encoding, step count and output bundle live here.
package stepper_scheduler_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned STEPS   = 8;
    localparam int unsigned STEP_W  = 3;
    localparam int unsigned REQ_W   = 2;
    localparam int unsigned DWELL_W = 8;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
    localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

    // Index of the final advance in a pass; wrapping past it returns the stepper to s0.
    localparam logic [STEP_W-1:0] LAST_INDEX = STEP_W'(STEPS - 1);

    typedef struct packed {
        logic              advance;
        logic [REQ_W-1:0]  grant;
        logic              busy;
        logic              done;
        logic [STEP_W-1:0] step_index;
    } sched_out_t;

    // Single requester wins outright; on contention the round-robin pointer decides.
    function automatic logic [REQ_W-1:0] rr_pick(input logic [REQ_W-1:0] req,
                                                 input logic [REQ_W-1:0] ptr);
        logic [REQ_W-1:0] pick;
        pick = req;
        if (req == '1) begin
            pick = ptr;
        end
        return pick;
    endfunction

endpackage

// File: rtl/stepper_scheduler_if.sv
// Request/grant and stepper-drive signals between requesters and the scheduler.
// The master side owns the requests and hold; the scheduler drives the rest.
interface stepper_scheduler_if;
    import stepper_scheduler_pkg::*;

    logic [REQ_W-1:0]  req;
    logic              hold;
    logic              advance;
    logic [REQ_W-1:0]  grant;
    logic              busy;
    logic              done;
    logic [STEP_W-1:0] step_index;

    modport master (
        output req,
        output hold,
        input  advance,
        input  grant,
        input  busy,
        input  done,
        input  step_index
    );

    modport slave (
        input  req,
        input  hold,
        output advance,
        output grant,
        output busy,
        output done,
        output step_index
    );

endinterface

// File: rtl/stepper_scheduler_dwell_timer.sv
// Pacing counter: counts 0..DWELL-1 while enabled and not held, and strobes
// tick_c in the cycle it wraps so the caller can launch a paced action.
module stepper_scheduler_dwell_timer #(
    parameter int unsigned DWELL = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    input  logic hold,
    output logic tick_c
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] count;

    assign tick_c = en && !hold && (count == TERM);

    // Clear wins over counting; hold freezes the count, including at terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !hold) begin
            count <= tick_c ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/stepper_scheduler.sv
// Round-robin scheduler sharing the 8-state stepper between two requesters;
// each grant issues one full pass of paced advance pulses back to s0.
module stepper_scheduler
    import stepper_scheduler_pkg::*;
#(
    parameter int unsigned DWELL = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    stepper_scheduler_if.slave bus
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    sched_out_t         out_q;
    sched_out_t         out_nxt;
    logic [REQ_W-1:0]   rr_ptr;
    logic [REQ_W-1:0]   rr_ptr_nxt;
    logic               final_q;
    logic               final_nxt;

    logic start_c;
    logic timer_en_c;
    logic timer_clr_c;
    logic tick_c;

    // The grant edge already counts as the first dwell cycle, so a pass with
    // DWELL=1 advances in the very first granted cycle.
    assign start_c     = (state == ST_IDLE) && (bus.req != '0);
    assign timer_en_c  = start_c || ((state == ST_RUN) && !final_q);
    assign timer_clr_c = (state != ST_RUN) && !start_c;

    stepper_scheduler_dwell_timer #(
        .DWELL (DWELL),
        .CNT_W (DWELL_W)
    ) u_dwell_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (timer_en_c),
        .clr    (timer_clr_c),
        .hold   (bus.hold),
        .tick_c (tick_c)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_nxt       = state;
        out_nxt         = out_q;
        out_nxt.advance = 1'b0;
        out_nxt.done    = 1'b0;
        rr_ptr_nxt      = rr_ptr;
        final_nxt       = final_q;

        case (state)
            ST_IDLE: begin
                out_nxt.grant      = '0;
                out_nxt.busy       = 1'b0;
                out_nxt.step_index = '0;
                final_nxt          = 1'b0;
                if (start_c) begin
                    state_nxt     = ST_RUN;
                    out_nxt.grant = rr_pick(bus.req, rr_ptr);
                    out_nxt.busy  = 1'b1;
                end
            end
            ST_RUN: begin
                if (final_q) begin
                    state_nxt    = ST_DONE;
                    out_nxt.done = 1'b1;
                    final_nxt    = 1'b0;
                end
            end
            ST_DONE: begin
                state_nxt     = ST_IDLE;
                out_nxt.grant = '0;
                out_nxt.busy  = 1'b0;
                rr_ptr_nxt    = {out_q.grant[0], out_q.grant[1]};
            end
            default: begin
                state_nxt = ST_IDLE;
                out_nxt   = '0;
                final_nxt = 1'b0;
            end
        endcase

        // A tick on the last index marks the pass complete; the wrap lands on 0.
        if (tick_c) begin
            out_nxt.advance = 1'b1;
            if (out_nxt.step_index == LAST_INDEX) begin
                final_nxt = 1'b1;
            end
            out_nxt.step_index = out_nxt.step_index + STEP_W'(1);
        end
    end

    // State, pointer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            out_q   <= '0;
            rr_ptr  <= 2'b01;
            final_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            out_q   <= out_nxt;
            rr_ptr  <= rr_ptr_nxt;
            final_q <= final_nxt;
        end
    end

    assign bus.advance    = out_q.advance;
    assign bus.grant      = out_q.grant;
    assign bus.busy       = out_q.busy;
    assign bus.done       = out_q.done;
    assign bus.step_index = out_q.step_index;

endmodule
